// File: rtl/cascade_lane_dispatcher.sv
// cascade_lane_dispatcher
//   Hands window jobs to NUM_LANES classifier lanes in strict round-robin
//   order and retires their results in the same order. Each lane walks
//   IDLE -> RUN -> DONE -> IDLE. A lane that runs for TIMEOUT_CYCLES cycles
//   without reporting done is aborted and retired with a timeout flag.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   job_*                 job handshake (val/ready), window id and vnf
//   lane_start_o          one-cycle start pulse per lane
//   lane_vnf_o            registered vnf per lane, 32 bits per lane
//   lane_abort_o          one-cycle abort pulse on lane timeout
//   lane_done_i/result_i  per-lane completion pulse and face result
//   res_*                 in-order result handshake (val/ready), id, face, timeout
//   lanes_busy_o          lane not IDLE
//   windows_cnt_o         retired windows, saturating
//   faces_cnt_o           retired faces, saturating
//   err_o                 sticky: done pulse seen on a lane not in RUN
module cascade_lane_dispatcher #(
    parameter int NUM_LANES      = 4,
    parameter int ID_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_val_i,
    output logic                    job_ready_o,
    input  logic [ID_WIDTH-1:0]     job_id_i,
    input  logic [31:0]             job_vnf_i,
    output logic [NUM_LANES-1:0]    lane_start_o,
    output logic [32*NUM_LANES-1:0] lane_vnf_o,
    output logic [NUM_LANES-1:0]    lane_abort_o,
    input  logic [NUM_LANES-1:0]    lane_done_i,
    input  logic [NUM_LANES-1:0]    lane_result_i,
    output logic                    res_val_o,
    input  logic                    res_ready_i,
    output logic [ID_WIDTH-1:0]     res_id_o,
    output logic                    res_face_o,
    output logic                    res_timeout_o,
    output logic [NUM_LANES-1:0]    lanes_busy_o,
    output logic [31:0]             windows_cnt_o,
    output logic [31:0]             faces_cnt_o,
    output logic                    err_o
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);
    // Run-counter value at which a lane with no done is aborted next cycle.
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {L_IDLE, L_RUN, L_DONE} lane_state_t;

    lane_state_t         st     [NUM_LANES];
    logic [ID_WIDTH-1:0] id_r   [NUM_LANES];
    logic                face_r [NUM_LANES];
    logic                to_r   [NUM_LANES];
    logic [31:0]         cnt_r  [NUM_LANES];

    logic [PTR_W-1:0] dp;
    logic [PTR_W-1:0] rp;
    logic             dp_idle;
    logic             rp_done;
    logic             accept;
    logic             retire;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_LANE) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer-selected views of the lane array, built as a mux loop so the
    // pointer width never has to match the array index width exactly.
    always_comb begin
        dp_idle       = 1'b0;
        rp_done       = 1'b0;
        res_id_o      = '0;
        res_face_o    = 1'b0;
        res_timeout_o = 1'b0;
        lanes_busy_o  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lanes_busy_o[k] = (st[k] != L_IDLE);
            if (dp == PTR_W'(k)) begin
                dp_idle = (st[k] == L_IDLE);
            end
            if (rp == PTR_W'(k)) begin
                rp_done       = (st[k] == L_DONE);
                res_id_o      = id_r[k];
                res_face_o    = face_r[k];
                res_timeout_o = to_r[k];
            end
        end
    end

    assign job_ready_o = dp_idle;
    assign res_val_o   = rp_done;
    assign accept      = job_val_i & job_ready_o;
    assign retire      = res_val_o & res_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp            <= '0;
            rp            <= '0;
            lane_start_o  <= '0;
            lane_abort_o  <= '0;
            lane_vnf_o    <= '0;
            windows_cnt_o <= '0;
            faces_cnt_o   <= '0;
            err_o         <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                st[k]     <= L_IDLE;
                id_r[k]   <= '0;
                face_r[k] <= 1'b0;
                to_r[k]   <= 1'b0;
                cnt_r[k]  <= '0;
            end
        end else begin
            lane_start_o <= '0;
            lane_abort_o <= '0;

            if (accept) begin
                dp <= ptr_next(dp);
            end
            if (retire) begin
                rp            <= ptr_next(rp);
                windows_cnt_o <= sat_inc(windows_cnt_o);
                if (res_face_o) begin
                    faces_cnt_o <= sat_inc(faces_cnt_o);
                end
            end

            for (int k = 0; k < NUM_LANES; k++) begin
                case (st[k])
                    L_IDLE: begin
                        if (accept && (dp == PTR_W'(k))) begin
                            st[k]                <= L_RUN;
                            id_r[k]              <= job_id_i;
                            lane_vnf_o[32*k +: 32] <= job_vnf_i;
                            face_r[k]            <= 1'b0;
                            to_r[k]              <= 1'b0;
                            cnt_r[k]             <= '0;
                            lane_start_o[k]      <= 1'b1;
                        end
                    end
                    L_RUN: begin
                        // A done in the expiry cycle takes priority over the abort.
                        if (lane_done_i[k]) begin
                            st[k]     <= L_DONE;
                            face_r[k] <= lane_result_i[k];
                            to_r[k]   <= 1'b0;
                        end else if ((TIMEOUT_CYCLES > 0) && (cnt_r[k] == TO_LAST)) begin
                            st[k]           <= L_DONE;
                            face_r[k]       <= 1'b0;
                            to_r[k]         <= 1'b1;
                            lane_abort_o[k] <= 1'b1;
                        end else if (TIMEOUT_CYCLES > 0) begin
                            cnt_r[k] <= cnt_r[k] + 32'd1;
                        end
                    end
                    L_DONE: begin
                        if (retire && (rp == PTR_W'(k))) begin
                            st[k] <= L_IDLE;
                        end
                    end
                    default: st[k] <= L_IDLE;
                endcase

                if (lane_done_i[k] && (st[k] != L_RUN)) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cascade_lane_dispatcher.sv
`timescale 1ns/1ps
module tb_cascade_lane_dispatcher;

    localparam int NL  = 4;
    localparam int IDW = 16;
    localparam int TO  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              job_val;
    logic              job_ready;
    logic [IDW-1:0]    job_id;
    logic [31:0]       job_vnf;
    logic [NL-1:0]     lane_start;
    logic [32*NL-1:0]  lane_vnf;
    logic [NL-1:0]     lane_abort;
    logic [NL-1:0]     lane_done;
    logic [NL-1:0]     lane_result;
    logic              res_val;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic              res_face;
    logic              res_timeout;
    logic [NL-1:0]     lanes_busy;
    logic [31:0]       win_cnt;
    logic [31:0]       face_cnt;
    logic              err;

    // Lane inputs come either from hand-written sequences or from the
    // randomized lane responder.
    logic          auto_mode;
    logic [NL-1:0] man_done, man_res, auto_done, auto_res;
    assign lane_done   = auto_mode ? auto_done : man_done;
    assign lane_result = auto_mode ? auto_res  : man_res;

    cascade_lane_dispatcher #(
        .NUM_LANES(NL), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .job_val_i(job_val), .job_ready_o(job_ready), .job_id_i(job_id), .job_vnf_i(job_vnf),
        .lane_start_o(lane_start), .lane_vnf_o(lane_vnf), .lane_abort_o(lane_abort),
        .lane_done_i(lane_done), .lane_result_i(lane_result),
        .res_val_o(res_val), .res_ready_i(res_ready), .res_id_o(res_id),
        .res_face_o(res_face), .res_timeout_o(res_timeout),
        .lanes_busy_o(lanes_busy), .windows_cnt_o(win_cnt), .faces_cnt_o(face_cnt),
        .err_o(err)
    );

    // Single-lane instance for the throughput check.
    logic           s_job_val, s_job_ready, s_lane_start, s_lane_abort, s_done, s_result;
    logic [IDW-1:0] s_job_id, s_res_id;
    logic [31:0]    s_job_vnf, s_lane_vnf, s_win_cnt, s_face_cnt;
    logic           s_res_val, s_res_ready, s_res_face, s_res_timeout, s_busy, s_err;

    cascade_lane_dispatcher #(
        .NUM_LANES(1), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .job_val_i(s_job_val), .job_ready_o(s_job_ready), .job_id_i(s_job_id), .job_vnf_i(s_job_vnf),
        .lane_start_o(s_lane_start), .lane_vnf_o(s_lane_vnf), .lane_abort_o(s_lane_abort),
        .lane_done_i(s_done), .lane_result_i(s_result),
        .res_val_o(s_res_val), .res_ready_i(s_res_ready), .res_id_o(s_res_id),
        .res_face_o(s_res_face), .res_timeout_o(s_res_timeout),
        .lanes_busy_o(s_busy), .windows_cnt_o(s_win_cnt), .faces_cnt_o(s_face_cnt),
        .err_o(s_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        job_val = 1'b0; job_id = '0; job_vnf = '0; res_ready = 1'b0;
        auto_mode = 1'b0; man_done = '0; man_res = '0; auto_done = '0; auto_res = '0;
        s_job_val = 1'b0; s_job_id = '0; s_job_vnf = '0; s_res_ready = 1'b0;
        s_done = 1'b0; s_result = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_job(input logic [IDW-1:0] id, input logic [31:0] vnf);
        int w = 0;
        while (!job_ready && w < 50) begin
            tick();
            w++;
        end
        if (!job_ready) chk("send_job_wait", 64'(job_ready), 64'(1));
        job_val = 1'b1; job_id = id; job_vnf = vnf;
        tick();
        job_val = 1'b0;
    endtask

    // Expected retirement record. A randomized job's lane behaviour is a
    // function of its id: it reports done d = id % 10 cycles after its start
    // pulse with result id[4]; d beyond TO-1 means it never reports.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           face;
        logic           to;
    } exp_t;

    function automatic int lane_delay(input logic [IDW-1:0] id);
        return int'(id % 16'd10);
    endfunction

    function automatic exp_t make_exp(input logic [IDW-1:0] id);
        exp_t e;
        e.id   = id;
        e.to   = (lane_delay(id) > TO - 1);
        e.face = e.to ? 1'b0 : id[4];
        return e;
    endfunction

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    vnf;
        logic           result;
        logic [1:0]     rank;
        logic           exp_face;
    } ord_vec_t;

    ord_vec_t ov [4];

    exp_t           exp_q[$];
    logic [IDW-1:0] start_q[$];
    logic [NL-1:0]  active;
    logic [NL-1:0]  rres;
    int             due [NL];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int first_abort, n_abort, overlap, last_acc, start_c, rid, n_acc, sid, d;
        logic [31:0] m_win, m_face;
        logic [NL-1:0] bp_res;
        exp_t e;

        ov[0] = '{16'd1, 32'h100, 1'b1, 2'd2, 1'b1};
        ov[1] = '{16'd2, 32'h101, 1'b0, 2'd1, 1'b0};
        ov[2] = '{16'd3, 32'h102, 1'b1, 2'd3, 1'b1};
        ov[3] = '{16'd4, 32'h103, 1'b1, 2'd0, 1'b1};

        // ---------------- reset state
        do_reset();
        chk("rst_ctrl", 64'({job_ready, res_val, err, lanes_busy, lane_start, lane_abort}),
            64'({1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0}));
        chk("rst_res_fields", 64'({res_id, res_face, res_timeout}), 64'(0));
        chk("rst_counters", {win_cnt, face_cnt}, 64'(0));
        chk("rst_vnf_zero", 64'(lane_vnf == '0), 64'(1));

        // ---------------- ordering: lanes finish 3,1,0,2
        do_reset();
        for (int i = 0; i < 4; i++) send_job(ov[i].id, ov[i].vnf);
        chk("ord_busy", 64'(lanes_busy), 64'(4'hF));
        chk("ord_ready_full", 64'(job_ready), 64'(0));
        for (int i = 0; i < 4; i++) begin
            chk("ord_vnf", 64'(lane_vnf[32*i +: 32]), 64'(ov[i].vnf));
            man_res[i] = ov[i].result;
        end
        for (int r = 0; r < 4; r++) begin
            man_done = '0;
            for (int i = 0; i < 4; i++) if (ov[i].rank == 2'(r)) man_done[i] = 1'b1;
            tick();
        end
        man_done = '0;
        for (int i = 0; i < 4; i++) begin
            chk("ord_res", 64'({res_val, res_id, res_face, res_timeout}),
                64'({1'b1, ov[i].id, ov[i].exp_face, 1'b0}));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        chk("ord_empty", 64'(res_val), 64'(0));
        chk("ord_windows", 64'(win_cnt), 64'(4));
        chk("ord_faces", 64'(face_cnt), 64'(3));

        // ---------------- backpressure
        do_reset();
        for (int i = 0; i < 4; i++) send_job(16'(16'h11 + i), 32'(32'h200 + i));
        bp_res = 4'b0101;
        man_res = bp_res;
        man_done = 4'hF;
        tick();
        man_done = '0;
        for (int c = 0; c < 20; c++) begin
            chk("bp_hold", 64'({job_ready, res_val, res_id, res_face, res_timeout}),
                64'({1'b0, 1'b1, 16'h11, 1'b1, 1'b0}));
            tick();
        end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", 64'({res_val, res_id, res_face}), 64'({1'b1, 16'(16'h11 + i), bp_res[i]}));
            tick();
        end
        res_ready = 1'b0;
        chk("bp_after", 64'({res_val, job_ready}), 64'(2'b01));
        chk("bp_counts", {win_cnt, face_cnt}, {32'd4, 32'd2});

        // ---------------- timeout: lane never reports
        do_reset();
        send_job(16'h55, 32'hABCD);
        chk("to_start", 64'(lane_start), 64'(4'b0001));
        first_abort = -1; n_abort = 0; overlap = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (lane_abort[0]) begin
                n_abort++;
                if (first_abort < 0) first_abort = c;
            end
            if (|(lane_start & lane_abort)) overlap++;
        end
        chk("to_abort_delay", 64'(first_abort), 64'(8));
        chk("to_abort_count", 64'(n_abort), 64'(1));
        chk("to_result", 64'({res_val, res_id, res_face, res_timeout}), 64'({1'b1, 16'h55, 1'b0, 1'b1}));

        // ---------------- done coincides with expiry
        do_reset();
        send_job(16'h66, 32'h1);
        n_abort = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            man_done = (c == 7) ? 4'b0001 : 4'b0000;
            man_res  = (c == 7) ? 4'b0001 : 4'b0000;
            if (|lane_abort) n_abort++;
        end
        man_done = '0; man_res = '0;
        chk("col_abort", 64'(n_abort), 64'(0));
        chk("col_result", 64'({res_val, res_id, res_face, res_timeout}), 64'({1'b1, 16'h66, 1'b1, 1'b0}));

        // ---------------- spurious done, then reset mid-run
        do_reset();
        man_done = 4'b0100;
        tick();
        man_done = '0;
        chk("err_set", 64'({err, lanes_busy, res_val, job_ready}), 64'({1'b1, 4'h0, 1'b0, 1'b1}));
        tick(); tick();
        chk("err_sticky", 64'(err), 64'(1));
        send_job(16'h77, 32'hDEAD_BEEF);
        send_job(16'h78, 32'h1234);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ctrl", 64'({job_ready, res_val, err, lanes_busy, lane_start, lane_abort}),
            64'({1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0}));
        chk("mid_rst_fields", 64'({res_id, res_face, res_timeout}), 64'(0));
        chk("mid_rst_vnf", 64'(lane_vnf == '0), 64'(1));
        n_abort = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (|lane_abort) n_abort++;
        end
        chk("mid_rst_no_abort", 64'(n_abort), 64'(0));

        // ---------------- randomized traffic against the scoreboard
        do_reset();
        auto_mode = 1'b1;
        exp_q.delete(); start_q.delete();
        active = '0; rres = '0;
        for (int k = 0; k < NL; k++) due[k] = 0;
        m_win = 0; m_face = 0;
        for (int c = 0; c < 5000; c++) begin
            bit feeding;
            feeding = (c < 3000);
            if (|(lane_start & lane_abort)) overlap++;
            chk("rnd_counts", {win_cnt, face_cnt}, {m_win, m_face});
            if (!feeding && exp_q.size() == 0) break;

            job_val   = feeding && ($urandom_range(0, 3) != 0);
            job_id    = 16'($urandom);
            job_vnf   = $urandom;
            res_ready = !feeding || ($urandom_range(0, 9) < 7);

            if (res_val && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_result", 64'(res_val), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_result", 64'({res_id, res_face, res_timeout}), 64'({e.id, e.face, e.to}));
                    m_win++;
                    if (e.face) m_face++;
                end
            end

            auto_done = '0; auto_res = '0;
            for (int k = 0; k < NL; k++) begin
                if (active[k] && due[k] == c) begin
                    auto_done[k] = 1'b1;
                    auto_res[k]  = rres[k];
                    active[k]    = 1'b0;
                end
            end
            for (int k = 0; k < NL; k++) begin
                if (lane_start[k]) begin
                    if (start_q.size() == 0) begin
                        chk("rnd_spurious_start", 64'(lane_start[k]), 64'(0));
                    end else begin
                        sid = int'(start_q.pop_front());
                        d = lane_delay(16'(sid));
                        if (d <= TO - 1) begin
                            if (d == 0) begin
                                auto_done[k] = 1'b1;
                                auto_res[k]  = sid[4];
                            end else begin
                                active[k] = 1'b1;
                                due[k]    = c + d;
                                rres[k]   = sid[4];
                            end
                        end
                    end
                end
            end

            if (job_val && job_ready) begin
                exp_q.push_back(make_exp(job_id));
                start_q.push_back(job_id);
            end
            tick();
        end
        job_val = 1'b0; res_ready = 1'b0; auto_mode = 1'b0;
        chk("rnd_drained", 64'(exp_q.size()), 64'(0));
        chk("rnd_busy", 64'(lanes_busy), 64'(0));
        chk("rnd_err", 64'(err), 64'(0));
        chk("rnd_overlap", 64'(overlap), 64'(0));

        // ---------------- single-lane throughput
        do_reset();
        s_res_ready = 1'b1;
        s_job_val   = 1'b1;
        start_c = -100; last_acc = -1; rid = 0; n_acc = 0;
        for (int c = 0; c < 64; c++) begin
            s_job_id  = 16'(n_acc);
            s_job_vnf = 32'(32'h300 + n_acc);
            if (s_res_val) begin
                chk("tp_res_id", 64'({s_res_id, s_res_face, s_res_timeout}), 64'({16'(rid), 1'b1, 1'b0}));
                rid++;
            end
            if (s_job_ready) begin
                if (last_acc >= 0) chk("tp_interval", 64'(c - last_acc), 64'(5));
                last_acc = c;
                n_acc++;
            end
            if (s_lane_start) start_c = c;
            s_done   = (c == start_c + 2);
            s_result = 1'b1;
            tick();
        end
        s_job_val = 1'b0; s_done = 1'b0;
        chk("tp_accepts", 64'(n_acc), 64'(13));
        chk("tp_counts", {s_win_cnt, s_face_cnt}, {32'(rid), 32'(rid)});
        chk("tp_misc", 64'({s_err, s_lane_abort, s_busy}), 64'({1'b0, 1'b0, 1'b1}));
        chk("tp_vnf", 64'(s_lane_vnf), 64'(32'h300 + 32'(n_acc - 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
